// File: rtl/vid_timing_src_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vid_timing_src_pkg
//  Brief    : Shared FSM encoding and video timing presets for vid_timing_src.
//  Revision : 1.0 - initial release
// ============================================================================
package vid_timing_src_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // 640x480@60 (25.175 MHz pixel clock)
    localparam int c_VGA_H_SYNC  = 96;
    localparam int c_VGA_H_BACK  = 48;
    localparam int c_VGA_H_DISP  = 640;
    localparam int c_VGA_H_FRONT = 16;
    localparam int c_VGA_V_SYNC  = 2;
    localparam int c_VGA_V_BACK  = 33;
    localparam int c_VGA_V_DISP  = 480;
    localparam int c_VGA_V_FRONT = 10;

    // 800x480 parallel-RGB LCD panel
    localparam int c_LCD_H_SYNC  = 128;
    localparam int c_LCD_H_BACK  = 88;
    localparam int c_LCD_H_DISP  = 800;
    localparam int c_LCD_H_FRONT = 40;
    localparam int c_LCD_V_SYNC  = 2;
    localparam int c_LCD_V_BACK  = 33;
    localparam int c_LCD_V_DISP  = 480;
    localparam int c_LCD_V_FRONT = 10;

    function automatic int axis_total(input int sync, input int back,
                                      input int disp, input int front);
        return sync + back + disp + front;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_axis_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : vid_axis_cnt
//  Brief    : One timing axis: wrapping counter with sync/active region decode.
//  Revision : 1.0 - initial release
// ============================================================================
module vid_axis_cnt
    import vid_timing_src_pkg::*;
#(
    parameter int SYNC  = 96,
    parameter int BACK  = 48,
    parameter int DISP  = 640,
    parameter int FRONT = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic        at_last,
    output logic        is_zero,
    output logic        in_sync,
    output logic        in_active,
    output logic [10:0] pos
);

    localparam logic [11:0] c_LAST   = 12'(axis_total(SYNC, BACK, DISP, FRONT) - 1);
    localparam logic [11:0] c_SYNC   = 12'(SYNC);
    localparam logic [11:0] c_ACT_LO = 12'(SYNC + BACK);
    localparam logic [11:0] c_ACT_HI = 12'(SYNC + BACK + DISP);

    logic [11:0] r_cnt;

    // clr holds the axis at the origin while the source is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 12'd1;
        end
    end

    assign at_last   = (r_cnt == c_LAST);
    assign is_zero   = (r_cnt == 12'd0);
    assign in_sync   = (r_cnt < c_SYNC);
    assign in_active = (r_cnt >= c_ACT_LO) && (r_cnt < c_ACT_HI);
    assign pos       = in_active ? 11'(r_cnt - c_ACT_LO) : 11'd0;

endmodule
`default_nettype wire

// File: rtl/vid_timing_src.sv
`default_nettype none
// ============================================================================
//  Module   : vid_timing_src
//  Brief    : Frame timing generator and pixel source for the vip pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module vid_timing_src
    import vid_timing_src_pkg::*;
#(
    parameter int   H_SYNC   = c_VGA_H_SYNC,
    parameter int   H_BACK   = c_VGA_H_BACK,
    parameter int   H_DISP   = c_VGA_H_DISP,
    parameter int   H_FRONT  = c_VGA_H_FRONT,
    parameter int   V_SYNC   = c_VGA_V_SYNC,
    parameter int   V_BACK   = c_VGA_V_BACK,
    parameter int   V_DISP   = c_VGA_V_DISP,
    parameter int   V_FRONT  = c_VGA_V_FRONT,
    parameter logic SYNC_POL = 1'b0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        pix_req,
    input  logic [15:0] pix_data,
    output logic        frame_vsync,
    output logic        frame_hsync,
    output logic        frame_de,
    output logic [15:0] frame_rgb,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        frame_start,
    output logic        busy
);

    state_t      r_state;
    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;
    logic [10:0] r_xpos;
    logic [10:0] r_ypos;
    logic        r_frame_start;

    logic        w_run;
    logic        w_h_last, w_h_zero, w_h_sync, w_h_act;
    logic        w_v_last, w_v_zero, w_v_sync, w_v_act;
    logic [10:0] w_h_pos, w_v_pos;
    logic        w_eof;
    logic        w_pix_req;

    assign w_run = (r_state == ST_RUN);

    vid_axis_cnt #(
        .SYNC  (H_SYNC),
        .BACK  (H_BACK),
        .DISP  (H_DISP),
        .FRONT (H_FRONT)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .clr       (~w_run),
        .inc       (1'b1),
        .at_last   (w_h_last),
        .is_zero   (w_h_zero),
        .in_sync   (w_h_sync),
        .in_active (w_h_act),
        .pos       (w_h_pos)
    );

    vid_axis_cnt #(
        .SYNC  (V_SYNC),
        .BACK  (V_BACK),
        .DISP  (V_DISP),
        .FRONT (V_FRONT)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .clr       (~w_run),
        .inc       (w_h_last),
        .at_last   (w_v_last),
        .is_zero   (w_v_zero),
        .in_sync   (w_v_sync),
        .in_active (w_v_act),
        .pos       (w_v_pos)
    );

    assign w_eof     = w_h_last & w_v_last;
    assign w_pix_req = w_run & w_h_act & w_v_act;

    // Both counters wrap to zero at end of frame on their own, so staying in
    // RUN there gives a gapless next frame; leaving only happens at that point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_xpos        <= '0;
            r_ypos        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (en)            r_state <= ST_RUN;
                ST_RUN:  if (w_eof && !en)  r_state <= ST_IDLE;
                default:                    r_state <= ST_IDLE;
            endcase
            r_de          <= w_pix_req;
            r_hsync       <= (w_run && w_h_sync) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_run && w_v_sync) ? SYNC_POL : ~SYNC_POL;
            r_xpos        <= w_pix_req ? w_h_pos : 11'd0;
            r_ypos        <= w_pix_req ? w_v_pos : 11'd0;
            r_frame_start <= w_run & w_h_zero & w_v_zero;
        end
    end

    assign pix_req     = w_pix_req;
    assign frame_de    = r_de;
    assign frame_hsync = r_hsync;
    assign frame_vsync = r_vsync;
    assign xpos        = r_xpos;
    assign ypos        = r_ypos;
    assign frame_start = r_frame_start;
    assign frame_rgb   = r_de ? pix_data : 16'h0000;
    assign busy        = w_run;

endmodule
`default_nettype wire
